input_port_rx: RTL and testbench

//  Leaf-side receive stage: takes BFT packets addressed to this port and

---
 rtl/input_port_rx.sv | 144 ++++++++++++++
 tb/tb_input_port_rx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_rx.sv
// Leaf-side BFT receive stage: stores packets by slot address, hands payloads
// to the user strictly in slot order, and requests credit returns as words drain.
module input_port_rx #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_bft,
    input  logic                     reset_bft,
    input  logic [PACKET_BITS-1:0]   internal_in,
    input  logic                     in_sel,
    input  logic                     cfg_src_en,
    input  logic [NUM_LEAF_BITS-1:0] cfg_src_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_src_port,
    output logic [PAYLOAD_BITS-1:0]  dout_interface2user,
    output logic                     vld_interface2user,
    input  logic                     ack_user2interface,
    output logic                     credit_req,
    output logic [NUM_LEAF_BITS-1:0] credit_leaf,
    output logic [NUM_PORT_BITS-1:0] credit_port,
    input  logic                     credit_ack,
    output logic                     overflow_err
);

    localparam int DEPTH     = 2 ** NUM_ADDR_BITS;
    localparam int CNT_BITS  = $clog2(FREESPACE_UPDATE_SIZE) + 1;
    localparam int PEND_BITS = NUM_ADDR_BITS + 1;

    logic [PAYLOAD_BITS-1:0]  ram [DEPTH];

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [NUM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic                     vld_q, vld_d;
    logic [PAYLOAD_BITS-1:0]  dout_q, dout_d;
    logic [CNT_BITS-1:0]      cons_cnt_q, cons_cnt_d;
    logic [PEND_BITS-1:0]     credit_pend_q, credit_pend_d;
    logic [NUM_LEAF_BITS-1:0] credit_leaf_q, credit_leaf_d;
    logic [NUM_PORT_BITS-1:0] credit_port_q, credit_port_d;
    logic                     overflow_q, overflow_d;

    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic                     pkt_hit, wr_en, rd_en, user_ack, credit_inc, credit_dec;
    logic                     unused_hdr;

    assign unused_hdr = ^internal_in[PACKET_BITS-2:PAYLOAD_BITS+NUM_ADDR_BITS];

    // A write needs a free slot and a read needs a full one, so wr_en and rd_en
    // can never target the same slot: a same-cycle write to the head is dropped.
    always_comb begin
        wr_addr    = internal_in[PAYLOAD_BITS +: NUM_ADDR_BITS];
        pkt_hit    = in_sel && internal_in[PACKET_BITS-1];
        wr_en      = pkt_hit && !valid_q[wr_addr];
        user_ack   = vld_q && ack_user2interface;
        rd_en      = valid_q[rd_ptr_q] && (!vld_q || user_ack);
        credit_inc = user_ack && (cons_cnt_q == CNT_BITS'(FREESPACE_UPDATE_SIZE - 1));
        credit_dec = credit_ack && (credit_pend_q != '0);
    end

    // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        valid_d       = valid_q;
        rd_ptr_d      = rd_ptr_q;
        vld_d         = vld_q;
        dout_d        = dout_q;
        cons_cnt_d    = cons_cnt_q;
        credit_pend_d = credit_pend_q;
        credit_leaf_d = credit_leaf_q;
        credit_port_d = credit_port_q;
        overflow_d    = overflow_q;

        if (rd_en) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + NUM_ADDR_BITS'(1);
            vld_d             = 1'b1;
            dout_d            = ram[rd_ptr_q];
        end else if (user_ack) begin
            vld_d = 1'b0;
        end

        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
        end
        if (pkt_hit && !wr_en) begin
            overflow_d = 1'b1;
        end

        if (user_ack) begin
            cons_cnt_d = credit_inc ? '0 : cons_cnt_q + CNT_BITS'(1);
        end
        case ({credit_inc, credit_dec})
            2'b10:   credit_pend_d = credit_pend_q + PEND_BITS'(1);
            2'b01:   credit_pend_d = credit_pend_q - PEND_BITS'(1);
            default: credit_pend_d = credit_pend_q;
        endcase

        if (cfg_src_en) begin
            credit_leaf_d = cfg_src_leaf;
            credit_port_d = cfg_src_port;
        end
    end

    // NOTE: the payload RAM has no reset; valid_q gates every read, so stale words are never delivered.
    always_ff @(posedge clk_bft) begin
        if (wr_en) begin
            ram[wr_addr] <= internal_in[PAYLOAD_BITS-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_bft) begin
        if (reset_bft) begin
            valid_q       <= '0;
            rd_ptr_q      <= '0;
            vld_q         <= 1'b0;
            dout_q        <= '0;
            cons_cnt_q    <= '0;
            credit_pend_q <= '0;
            credit_leaf_q <= '0;
            credit_port_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rd_ptr_q      <= rd_ptr_d;
            vld_q         <= vld_d;
            dout_q        <= dout_d;
            cons_cnt_q    <= cons_cnt_d;
            credit_pend_q <= credit_pend_d;
            credit_leaf_q <= credit_leaf_d;
            credit_port_q <= credit_port_d;
            overflow_q    <= overflow_d;
        end
    end

    assign dout_interface2user = dout_q;
    assign vld_interface2user  = vld_q;
    assign credit_req          = (credit_pend_q != '0);
    assign credit_leaf         = credit_leaf_q;
    assign credit_port         = credit_port_q;
    assign overflow_err        = overflow_q;

endmodule

// File: tb/tb_input_port_rx.sv
// Scoreboard bench for input_port_rx: expected payloads are queued in delivery
// order as packets are driven and popped on every vld/ack handshake.
module tb_input_port_rx;

    localparam int PB  = 97;
    localparam int LB  = 6;
    localparam int PTB = 4;
    localparam int AB  = 7;
    localparam int DB  = 64;

    logic           clk_bft = 1'b0;
    logic           reset_bft;
    logic [PB-1:0]  internal_in;
    logic           in_sel;
    logic           cfg_src_en;
    logic [LB-1:0]  cfg_src_leaf;
    logic [PTB-1:0] cfg_src_port;
    logic [DB-1:0]  dout;
    logic           vld;
    logic           ack;
    logic           credit_req;
    logic [LB-1:0]  credit_leaf;
    logic [PTB-1:0] credit_port;
    logic           credit_ack;
    logic           overflow_err;

    logic [DB-1:0]  exp_q[$];
    logic [DB-1:0]  exp_word;
    int             errors = 0;
    int             checks = 0;

    always #5 clk_bft = ~clk_bft;

    input_port_rx dut (
        .clk_bft            (clk_bft),
        .reset_bft          (reset_bft),
        .internal_in        (internal_in),
        .in_sel             (in_sel),
        .cfg_src_en         (cfg_src_en),
        .cfg_src_leaf       (cfg_src_leaf),
        .cfg_src_port       (cfg_src_port),
        .dout_interface2user(dout),
        .vld_interface2user (vld),
        .ack_user2interface (ack),
        .credit_req         (credit_req),
        .credit_leaf        (credit_leaf),
        .credit_port        (credit_port),
        .credit_ack         (credit_ack),
        .overflow_err       (overflow_err)
    );

    // Scoreboard: every handshake the next edge will see is compared here.
    always @(negedge clk_bft) begin
        if (!reset_bft && vld && ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: got dout=%h but no word expected", dout);
            end else begin
                exp_word = exp_q.pop_front();
                if (dout !== exp_word) begin
                    errors++;
                    $display("FAIL deliver: dout=%h expected %h", dout, exp_word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic do_reset();
        reset_bft   = 1'b1;
        in_sel      = 1'b0;
        internal_in = '0;
        ack         = 1'b0;
        credit_ack  = 1'b0;
        cfg_src_en  = 1'b0;
        tick();
        tick();
        reset_bft = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [AB-1:0] addr, input logic [DB-1:0] data);
        logic [PB-1:0] pkt;
        pkt            = '0;
        pkt[PB-1]      = 1'b1;
        pkt[DB +: AB]  = addr;
        pkt[DB-1:0]    = data;
        internal_in    = pkt;
        in_sel         = 1'b1;
        tick();
        in_sel      = 1'b0;
        internal_in = '0;
    endtask

    task automatic stream(input int first, input int count);
        logic [DB-1:0] w;
        for (int i = first; i < first + count; i++) begin
            w = {$urandom, $urandom};
            exp_q.push_back(w);
            send(AB'(i), w);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vld) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || vld) begin
            errors++;
            $display("FAIL %s_drain: %0d words left, vld=%b, required 0 left and vld=0", name, exp_q.size(), vld);
        end
    endtask

    task automatic wait_vld(input string name);
        int n;
        n = 0;
        while (!vld && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!vld) begin
            errors++;
            $display("FAIL %s_vld_timeout: vld=%b required 1", name, vld);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (vld !== 1'b0)           begin errors++; $display("FAIL reset_vld: got %b want 0", vld); end
        if (dout !== '0)            begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
        if (credit_req !== 1'b0)    begin errors++; $display("FAIL reset_credit_req: got %b want 0", credit_req); end
        if (credit_leaf !== '0)     begin errors++; $display("FAIL reset_leaf: got %h want 0", credit_leaf); end
        if (credit_port !== '0)     begin errors++; $display("FAIL reset_port: got %h want 0", credit_port); end
        if (overflow_err !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
    endtask

    task automatic test_cfg();
        cfg_src_leaf = 6'h2A;
        cfg_src_port = 4'h9;
        cfg_src_en   = 1'b1;
        tick();
        cfg_src_en   = 1'b0;
        cfg_src_leaf = 6'h15;
        cfg_src_port = 4'h3;
        tick();
        checks += 2;
        if (credit_leaf !== 6'h2A) begin errors++; $display("FAIL cfg_leaf: got %h want 2a", credit_leaf); end
        if (credit_port !== 4'h9)  begin errors++; $display("FAIL cfg_port: got %h want 9", credit_port); end
    endtask

    task automatic test_single();
        do_reset();
        exp_q.push_back(64'hA5);
        send(7'd0, 64'hA5);
        checks++;
        if (vld !== 1'b0) begin errors++; $display("FAIL single_latency_early: vld=%b want 0", vld); end
        tick();
        checks += 2;
        if (vld !== 1'b1)    begin errors++; $display("FAIL single_vld: vld=%b want 1", vld); end
        if (dout !== 64'hA5) begin errors++; $display("FAIL single_dout: dout=%h want a5", dout); end
        tick();
        checks++;
        if (vld !== 1'b1) begin errors++; $display("FAIL single_hold: vld=%b want 1 without ack", vld); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (vld !== 1'b0) begin errors++; $display("FAIL single_after_ack: vld=%b want 0", vld); end
    endtask

    task automatic test_out_of_order();
        logic [DB-1:0] w [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w[i] = {$urandom, $urandom};
            exp_q.push_back(w[i]);
        end
        send(7'd2, w[2]);
        send(7'd1, w[1]);
        tick();
        checks++;
        if (vld !== 1'b0) begin errors++; $display("FAIL ooo_held: vld=%b want 0 before slot 0", vld); end
        send(7'd0, w[0]);
        tick();
        checks += 2;
        if (vld !== 1'b1)  begin errors++; $display("FAIL ooo_vld: vld=%b want 1", vld); end
        if (dout !== w[0]) begin errors++; $display("FAIL ooo_head: dout=%h want %h", dout, w[0]); end
        ack = 1'b1;
        tick();
        tick();
        tick();
        ack = 1'b0;
        checks += 2;
        if (vld !== 1'b0)        begin errors++; $display("FAIL ooo_end_vld: vld=%b want 0", vld); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL ooo_stream: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_stream_wrap();
        int n;
        logic [DB-1:0] w;
        do_reset();
        ack = 1'b1;
        stream(0, 128);
        wait_drain("wrap");
        n = 0;
        while (credit_req && n < 8) begin
            credit_ack = 1'b1;
            tick();
            n++;
        end
        credit_ack = 1'b0;
        checks++;
        if (n != 2) begin errors++; $display("FAIL wrap_credits: got %0d credit returns want 2", n); end
        w = {$urandom, $urandom};
        exp_q.push_back(w);
        send(7'd0, w);
        wait_drain("wrap_slot0");
        checks += 2;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b want 0", overflow_err); end
        if (credit_req !== 1'b0)   begin errors++; $display("FAIL wrap_credit_idle: got %b want 0", credit_req); end
        ack = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DB-1:0] w [6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            w[i] = {$urandom, $urandom};
            exp_q.push_back(w[i]);
        end
        send(7'd5, w[5]);
        checks++;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_first: got %b want 0", overflow_err); end
        send(7'd5, 64'hDEAD_BEEF_0BAD_F00D);
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
        for (int i = 0; i < 5; i++) send(AB'(i), w[i]);
        ack = 1'b1;
        wait_drain("ovf");
        ack = 1'b0;
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_credit_collision();
        logic [DB-1:0] w;
        do_reset();
        ack = 1'b1;
        stream(0, 64);
        wait_drain("coll_a");
        checks++;
        if (credit_req !== 1'b1) begin errors++; $display("FAIL coll_first_credit: got %b want 1", credit_req); end
        stream(64, 63);
        wait_drain("coll_b");
        ack = 1'b0;
        w = {$urandom, $urandom};
        exp_q.push_back(w);
        send(7'd127, w);
        wait_vld("coll");
        ack        = 1'b1;
        credit_ack = 1'b1;
        tick();
        ack        = 1'b0;
        credit_ack = 1'b0;
        checks++;
        if (credit_req !== 1'b1) begin errors++; $display("FAIL coll_same_cycle: credit_req=%b want 1", credit_req); end
        credit_ack = 1'b1;
        tick();
        credit_ack = 1'b0;
        checks++;
        if (credit_req !== 1'b0) begin errors++; $display("FAIL coll_pend_one: credit_req=%b want 0", credit_req); end
    endtask

    task automatic test_mid_reset();
        logic [DB-1:0] w;
        do_reset();
        ack = 1'b1;
        stream(0, 64);
        wait_drain("mrst");
        ack = 1'b0;
        stream(64, 3);
        wait_vld("mrst");
        checks++;
        if (credit_req !== 1'b1) begin errors++; $display("FAIL mrst_pre_credit: got %b want 1", credit_req); end
        reset_bft = 1'b1;
        tick();
        reset_bft = 1'b0;
        exp_q.delete();
        checks += 3;
        if (vld !== 1'b0)        begin errors++; $display("FAIL mrst_vld: got %b want 0", vld); end
        if (credit_req !== 1'b0) begin errors++; $display("FAIL mrst_credit: got %b want 0", credit_req); end
        if (dout !== '0)         begin errors++; $display("FAIL mrst_dout: got %h want 0", dout); end
        w = {$urandom, $urandom};
        exp_q.push_back(w);
        send(7'd0, w);
        tick();
        checks++;
        if (vld !== 1'b1) begin errors++; $display("FAIL mrst_new_vld: got %b want 1", vld); end
        ack = 1'b1;
        wait_drain("mrst_new");
        ack = 1'b0;
    endtask

    initial begin
        reset_bft    = 1'b1;
        internal_in  = '0;
        in_sel       = 1'b0;
        cfg_src_en   = 1'b0;
        cfg_src_leaf = '0;
        cfg_src_port = '0;
        ack          = 1'b0;
        credit_ack   = 1'b0;

        test_reset();
        test_cfg();
        test_single();
        test_out_of_order();
        test_stream_wrap();
        test_overflow();
        test_credit_collision();
        test_mid_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
